// File: rtl/data_path.sv
//==============================================================================
// Module   : data_path
// Brief    : Single-bus 32-bit CPU datapath slice (PC/IR/MAR/MDR/Y/Z/R1-R3 + ALU).
//            Define DATAPATH_MUL_EN to build the signed 32x32->64 multiplier.
// Revision : 1.0
//==============================================================================
`default_nettype none

module data_path #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PCout,
    input  logic             ZLOout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             ALUIn,
    input  logic             ZMuxEnable,
    input  logic             ZSelect,
    input  logic             ZMuxOut,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [4:0]       alucontrol,
    output logic [WIDTH-1:0] out
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_SUB  = 5'b00001;
    localparam logic [4:0] c_OP_SHR  = 5'b00010;
    localparam logic [4:0] c_OP_SHRA = 5'b00011;
    localparam logic [4:0] c_OP_SHL  = 5'b00100;
    localparam logic [4:0] c_OP_ROR  = 5'b00101;
    localparam logic [4:0] c_OP_ROL  = 5'b00110;
    localparam logic [4:0] c_OP_NEG  = 5'b00111;
    localparam logic [4:0] c_OP_NOT  = 5'b01000;
    localparam logic [4:0] c_OP_MUL  = 5'b01001;
    localparam logic [4:0] c_OP_AND  = 5'b10000;
    localparam logic [4:0] c_OP_OR   = 5'b10001;

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [WIDTH-1:0] ir_q,  ir_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] y_q,   y_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic [WIDTH-1:0] r1_q,  r1_d;
    logic [WIDTH-1:0] r2_q,  r2_d;
    logic [WIDTH-1:0] r3_q,  r3_d;

    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_zmux;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_sra;
    logic [2*WIDTH-1:0] w_ror2;
    logic [2*WIDTH-1:0] w_rol2;
    logic [2*WIDTH-1:0] w_alu;
    logic               w_unused;

    // Bus source priority: PC > ZLO > Z mux > MDR > R2 > R3; idle bus reads 0.
    assign w_zmux = ZSelect ? zhi_q : zlo_q;

    always_comb begin
        w_bus = '0;
        if (PCout)                        w_bus = pc_q;
        else if (ZLOout)                  w_bus = zlo_q;
        else if (ZMuxEnable && ZMuxOut)   w_bus = w_zmux;
        else if (MDRout)                  w_bus = mdr_q;
        else if (R2out)                   w_bus = r2_q;
        else if (R3out)                   w_bus = r3_q;
    end

    assign out = w_bus;

    // Rotates take the matching half of the value concatenated with itself.
    assign w_sh   = w_bus[SHW-1:0];
    assign w_sra  = WIDTH'($signed(y_q) >>> w_sh);
    assign w_ror2 = {y_q, y_q} >> w_sh;
    assign w_rol2 = {y_q, y_q} << w_sh;

`ifdef DATAPATH_MUL_EN
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign w_a_ext = {{WIDTH{y_q[WIDTH-1]}},   y_q};
    assign w_b_ext = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};
    assign w_prod  = w_a_ext * w_b_ext;
`endif

    always_comb begin
        w_alu = '0;
        case (alucontrol)
            c_OP_ADD:  w_alu = {{WIDTH{1'b0}}, y_q + w_bus};
            c_OP_SUB:  w_alu = {{WIDTH{1'b0}}, y_q - w_bus};
            c_OP_SHR:  w_alu = {{WIDTH{1'b0}}, y_q >> w_sh};
            c_OP_SHRA: w_alu = {{WIDTH{1'b0}}, w_sra};
            c_OP_SHL:  w_alu = {{WIDTH{1'b0}}, y_q << w_sh};
            c_OP_ROR:  w_alu = {{WIDTH{1'b0}}, w_ror2[WIDTH-1:0]};
            c_OP_ROL:  w_alu = {{WIDTH{1'b0}}, w_rol2[2*WIDTH-1:WIDTH]};
            c_OP_NEG:  w_alu = {{WIDTH{1'b0}}, -w_bus};
            c_OP_NOT:  w_alu = {{WIDTH{1'b0}}, ~w_bus};
`ifdef DATAPATH_MUL_EN
            c_OP_MUL:  w_alu = w_prod;
`else
            c_OP_MUL:  w_alu = '0;
`endif
            c_OP_AND:  w_alu = {{WIDTH{1'b0}}, y_q & w_bus};
            c_OP_OR:   w_alu = {{WIDTH{1'b0}}, y_q | w_bus};
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        pc_d  = PCin  ? w_bus : pc_q;
        ir_d  = IRin  ? w_bus : ir_q;
        mar_d = MARin ? w_bus : mar_q;
        mdr_d = MDRin ? (Read ? Mdatain : w_bus) : mdr_q;
        y_d   = Yin   ? w_bus : y_q;
        r1_d  = R1in  ? w_bus : r1_q;
        r2_d  = R2in  ? w_bus : r2_q;
        r3_d  = R3in  ? w_bus : r3_q;
        zhi_d = zhi_q;
        zlo_d = zlo_q;
        if (IncPC) begin
            zhi_d = '0;
            zlo_d = w_bus + WIDTH'(1);
        end else if (ALUIn) begin
            {zhi_d, zlo_d} = w_alu;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
        end
    end

    // IR, MAR and R1 feed logic outside this slice.
    assign w_unused = ^{ir_q, mar_q, r1_q};

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
//==============================================================================
// Module   : tb_data_path
// Brief    : Directed self-checking bench for data_path.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_data_path;

    logic        clock;
    logic        reset;
    logic        PCout, ZLOout, MDRout, R2out, R3out;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic        R1in, R2in, R3in, ALUIn, ZMuxEnable, ZSelect, ZMuxOut;
    logic [31:0] Mdatain;
    logic [4:0]  alucontrol;
    logic [31:0] out;

    int tests_run    = 0;
    int tests_failed = 0;

    data_path #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .PCout      (PCout),
        .ZLOout     (ZLOout),
        .MDRout     (MDRout),
        .R2out      (R2out),
        .R3out      (R3out),
        .MARin      (MARin),
        .PCin       (PCin),
        .MDRin      (MDRin),
        .IRin       (IRin),
        .Yin        (Yin),
        .IncPC      (IncPC),
        .Read       (Read),
        .R1in       (R1in),
        .R2in       (R2in),
        .R3in       (R3in),
        .ALUIn      (ALUIn),
        .ZMuxEnable (ZMuxEnable),
        .ZSelect    (ZSelect),
        .ZMuxOut    (ZMuxOut),
        .Mdatain    (Mdatain),
        .alucontrol (alucontrol),
        .out        (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clr();
        reset = 0; PCout = 0; ZLOout = 0; MDRout = 0; R2out = 0; R3out = 0;
        MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
        R1in = 0; R2in = 0; R3in = 0; ALUIn = 0; ZMuxEnable = 0; ZSelect = 0;
        ZMuxOut = 0; Mdatain = '0; alucontrol = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clr();
        Mdatain = v; Read = 1; MDRin = 1;
        step();
        clr();
    endtask

    task automatic test_reset();
        clr();
        reset = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'hDEAD_BEEF;
        step();
        clr();
        #1;
        tests_run++;
        if (out !== 32'h0) begin tests_failed++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
        tests_run++;
        if (dut.pc_q !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_q, 32'h0); end
        tests_run++;
        if (dut.mdr_q !== 32'h0) begin tests_failed++; $display("FAIL reset_mdr got=%h exp=%h", dut.mdr_q, 32'h0); end
    endtask

    task automatic test_fetch();
        clr(); reset = 1; step(); clr();
        PCout = 1; MARin = 1; IncPC = 1;
        step(); clr();
        tests_run++;
        if (dut.mar_q !== 32'h0) begin tests_failed++; $display("FAIL fetch_mar got=%h exp=%h", dut.mar_q, 32'h0); end
        tests_run++;
        if ({dut.zhi_q, dut.zlo_q} !== 64'h1) begin tests_failed++; $display("FAIL fetch_z got=%h exp=%h", {dut.zhi_q, dut.zlo_q}, 64'h1); end
        ZLOout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2891_8000;
        step(); clr();
        PCout = 1; #1;
        tests_run++;
        if (out !== 32'h1) begin tests_failed++; $display("FAIL fetch_pc got=%h exp=%h", out, 32'h1); end
        clr();
        MDRout = 1; IRin = 1;
        step(); clr();
        tests_run++;
        if (dut.ir_q !== 32'h2891_8000) begin tests_failed++; $display("FAIL fetch_ir got=%h exp=%h", dut.ir_q, 32'h2891_8000); end
    endtask

    task automatic test_reg_load();
        logic [31:0] vals [3] = '{32'h41, 32'h05, 32'h18};
        logic [31:0] got;
        for (int i = 0; i < 3; i++) begin
            load_mdr(vals[i]);
            MDRout = 1; #1;
            tests_run++;
            if (out !== vals[i]) begin tests_failed++; $display("FAIL regload_bus%0d got=%h exp=%h", i, out, vals[i]); end
            case (i)
                0:       R2in = 1;
                1:       R3in = 1;
                default: R1in = 1;
            endcase
            step(); clr();
            case (i)
                0:       begin R2out = 1; #1; got = out; end
                1:       begin R3out = 1; #1; got = out; end
                default: got = dut.r1_q;
            endcase
            clr();
            tests_run++;
            if (got !== vals[i]) begin tests_failed++; $display("FAIL regload_dst%0d got=%h exp=%h", i, got, vals[i]); end
        end
    endtask

    task automatic test_and();
        clr();
        R2out = 1; Yin = 1; alucontrol = 5'b10000;
        step(); clr();
        tests_run++;
        if (dut.y_q !== 32'h41) begin tests_failed++; $display("FAIL and_y got=%h exp=%h", dut.y_q, 32'h41); end
        R3out = 1; ALUIn = 1; alucontrol = 5'b10000;
        step(); clr();
        tests_run++;
        if ({dut.zhi_q, dut.zlo_q} !== 64'h1) begin tests_failed++; $display("FAIL and_z got=%h exp=%h", {dut.zhi_q, dut.zlo_q}, 64'h1); end
        ZMuxOut = 1; #1;
        tests_run++;
        if (out !== 32'h0) begin tests_failed++; $display("FAIL zmux_disabled got=%h exp=%h", out, 32'h0); end
        ZMuxEnable = 1; R1in = 1; #1;
        tests_run++;
        if (out !== 32'h1) begin tests_failed++; $display("FAIL and_bus got=%h exp=%h", out, 32'h1); end
        step(); clr();
        tests_run++;
        if (dut.r1_q !== 32'h1) begin tests_failed++; $display("FAIL and_r1 got=%h exp=%h", dut.r1_q, 32'h1); end
    endtask

    task automatic test_alu_sweep();
        logic [31:0] ya [15] = '{32'hFFFFFFFF, 32'h0, 32'h80000001, 32'h80000000, 32'h5,
                                 32'h80000000, 32'h1, 32'h1, 32'h5, 32'h0,
                                 32'hF0, 32'h12345678, 32'hF0F0F0F0, 32'h12345678, 32'h9};
        logic [31:0] ba [15] = '{32'h1, 32'h1, 32'h1, 32'h4, 32'h7,
                                 32'h4, 32'h1F, 32'h1, 32'h1, 32'h0F0F0F0F,
                                 32'h0F, 32'h20, 32'hFF00FF00, 32'h24, 32'h3};
        logic [4:0]  op [15] = '{5'b00000, 5'b00001, 5'b00110, 5'b00011, 5'b11111,
                                 5'b00010, 5'b00100, 5'b00101, 5'b00111, 5'b01000,
                                 5'b10001, 5'b00010, 5'b10000, 5'b00101, 5'b01010};
        logic [31:0] ex [15] = '{32'h0, 32'hFFFFFFFF, 32'h3, 32'hF8000000, 32'h0,
                                 32'h08000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                 32'hFF, 32'h12345678, 32'hF000F000, 32'h81234567, 32'h0};
        for (int i = 0; i < 15; i++) begin
            load_mdr(ya[i]);
            MDRout = 1; Yin = 1; step(); clr();
            load_mdr(ba[i]);
            MDRout = 1; ALUIn = 1; alucontrol = op[i]; step(); clr();
            ZLOout = 1; #1;
            tests_run++;
            if (out !== ex[i]) begin tests_failed++; $display("FAIL alu_lo%0d op=%b got=%h exp=%h", i, op[i], out, ex[i]); end
            clr();
            ZMuxEnable = 1; ZMuxOut = 1; ZSelect = 1; #1;
            tests_run++;
            if (out !== 32'h0) begin tests_failed++; $display("FAIL alu_hi%0d op=%b got=%h exp=%h", i, op[i], out, 32'h0); end
            clr();
        end
    endtask

    task automatic test_mul();
        logic [63:0] exp_z;
`ifdef DATAPATH_MUL_EN
        exp_z = 64'hFFFFFFFF_FFFFFFFE;
`else
        exp_z = 64'h0;
`endif
        load_mdr(32'hFFFFFFFF);
        MDRout = 1; Yin = 1; step(); clr();
        load_mdr(32'h2);
        MDRout = 1; ALUIn = 1; alucontrol = 5'b00000; step(); clr();
        ZLOout = 1; #1;
        tests_run++;
        if (out !== 32'h1) begin tests_failed++; $display("FAIL mul_pre got=%h exp=%h", out, 32'h1); end
        clr();
        MDRout = 1; ALUIn = 1; alucontrol = 5'b01001; step(); clr();
        ZLOout = 1; #1;
        tests_run++;
        if (out !== exp_z[31:0]) begin tests_failed++; $display("FAIL mul_lo got=%h exp=%h", out, exp_z[31:0]); end
        clr();
        ZMuxEnable = 1; ZMuxOut = 1; ZSelect = 1; #1;
        tests_run++;
        if (out !== exp_z[63:32]) begin tests_failed++; $display("FAIL mul_hi got=%h exp=%h", out, exp_z[63:32]); end
        clr();
    endtask

    task automatic test_priority_reset();
        load_mdr(32'h18);
        PCout = 1; MDRout = 1; #1;
        tests_run++;
        if (out !== 32'h1) begin tests_failed++; $display("FAIL prio_pc got=%h exp=%h", out, 32'h1); end
        clr();
        ZMuxEnable = 1; ZMuxOut = 1; MDRout = 1; ZSelect = 1; #1;
        tests_run++;
        if (out !== dut_exp_hi()) begin tests_failed++; $display("FAIL prio_zmux got=%h exp=%h", out, dut_exp_hi()); end
        clr();
        PCout = 1; PCin = 1; step(); clr();
        PCout = 1; #1;
        tests_run++;
        if (out !== 32'h1) begin tests_failed++; $display("FAIL same_edge_pc got=%h exp=%h", out, 32'h1); end
        clr();
        load_mdr(32'h7);
        MDRout = 1; IncPC = 1; ALUIn = 1; alucontrol = 5'b10001; step(); clr();
        ZLOout = 1; #1;
        tests_run++;
        if (out !== 32'h8) begin tests_failed++; $display("FAIL incpc_override got=%h exp=%h", out, 32'h8); end
        clr();
        load_mdr(32'h18);
        reset = 1; R1in = 1; MDRout = 1; step(); clr();
        tests_run++;
        if (dut.r1_q !== 32'h0) begin tests_failed++; $display("FAIL midreset_r1 got=%h exp=%h", dut.r1_q, 32'h0); end
        tests_run++;
        if ({dut.zhi_q, dut.zlo_q, dut.y_q, dut.pc_q} !== 128'h0) begin
            tests_failed++; $display("FAIL midreset_regs got=%h exp=0", {dut.zhi_q, dut.zlo_q, dut.y_q, dut.pc_q});
        end
        MDRout = 1; #1;
        tests_run++;
        if (out !== 32'h0) begin tests_failed++; $display("FAIL midreset_mdr got=%h exp=%h", out, 32'h0); end
        clr();
    endtask

    // ZHI left by the multiply step: all-ones with the multiplier, zero without.
    function automatic logic [31:0] dut_exp_hi();
`ifdef DATAPATH_MUL_EN
        return 32'hFFFFFFFF;
`else
        return 32'h0;
`endif
    endfunction

    initial begin
        clr();
        test_reset();
        test_fetch();
        test_reg_load();
        test_and();
        test_alu_sweep();
        test_mul();
        test_priority_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
